// File: rtl/config_block_loader_if.sv
// Handshake and latch-bus signals between the chip config port and the block loader.
// The master drives the serial bitstream; the slave (loader) drives the latch bus.
interface config_block_loader_if #(
  parameter int MEM_SIZE   = 16,
  parameter int NUM_BLOCKS = 4
);
  logic                  cfg_start;
  logic                  cfg_bit;
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [MEM_SIZE-1:0]   config_in;
  logic [NUM_BLOCKS-1:0] comb_set;
  logic                  cfg_busy;
  logic                  cfg_done;

  modport master (
    output cfg_start, cfg_bit, cfg_valid,
    input  cfg_ready, config_in, comb_set, cfg_busy, cfg_done
  );

  modport slave (
    input  cfg_start, cfg_bit, cfg_valid,
    output cfg_ready, config_in, comb_set, cfg_busy, cfg_done
  );
endinterface

// File: rtl/config_block_loader.sv
// Serial bitstream to LUT latch-block loader: assembles MEM_SIZE-bit words LSB-first
// and strobes one comb_set per block, in block order, while config_in holds the word.
module config_block_loader #(
  parameter int MEM_SIZE   = 16,
  parameter int NUM_BLOCKS = 4,
  parameter int SET_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  config_block_loader_if.slave cfg
);
  localparam int BIT_W = (MEM_SIZE   > 1) ? $clog2(MEM_SIZE)   : 1;
  localparam int BLK_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int SET_W = (SET_CYCLES > 1) ? $clog2(SET_CYCLES) : 1;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(MEM_SIZE - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(NUM_BLOCKS - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SET_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [MEM_SIZE-1:0]   shreg_q;
  logic [MEM_SIZE-1:0]   word_q;
  logic [BIT_W-1:0]      bit_cnt_q;
  logic [BLK_W-1:0]      blk_idx_q;
  logic [SET_W-1:0]      set_cnt_q;
  logic [NUM_BLOCKS-1:0] strobe;
  logic                  accept;
  logic [MEM_SIZE-1:0]   shreg_next;

  assign accept     = cfg.cfg_valid && (state_q == SHIFT);
  assign shreg_next = {cfg.cfg_bit, shreg_q[MEM_SIZE-1:1]};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (cfg.cfg_start) state_d = SHIFT;
      SHIFT:  if (accept && (bit_cnt_q == BIT_LAST)) state_d = COMMIT;
      COMMIT: if (set_cnt_q == SET_LAST)
                state_d = (blk_idx_q == BLK_LAST) ? DONE : SHIFT;
      DONE:   if (cfg.cfg_start) state_d = SHIFT;
      default: state_d = IDLE;
    endcase
  end

  // word_q is only loaded on the edge into COMMIT, so it stays put through the
  // strobe and the whole next word's shift phase, covering the latch hold time.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q   <= '0;
      word_q    <= '0;
      bit_cnt_q <= '0;
      blk_idx_q <= '0;
      set_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (cfg.cfg_start) begin
            bit_cnt_q <= '0;
            blk_idx_q <= '0;
          end
        end
        SHIFT: begin
          if (accept) begin
            shreg_q <= shreg_next;
            if (bit_cnt_q == BIT_LAST) begin
              word_q    <= shreg_next;
              bit_cnt_q <= '0;
              set_cnt_q <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        COMMIT: begin
          if (set_cnt_q == SET_LAST) begin
            set_cnt_q <= '0;
            if (blk_idx_q != BLK_LAST) blk_idx_q <= blk_idx_q + 1'b1;
          end else begin
            set_cnt_q <= set_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    strobe = '0;
    if (state_q == COMMIT) strobe[blk_idx_q] = 1'b1;
  end

  assign cfg.comb_set  = strobe;
  assign cfg.config_in = word_q;
  assign cfg.cfg_ready = (state_q == SHIFT);
  assign cfg.cfg_busy  = (state_q == SHIFT) || (state_q == COMMIT);
  assign cfg.cfg_done  = (state_q == DONE);
endmodule
